// File: rtl/stack_port_pkg.sv
// Shared CPU stack definitions: command ops, stack pointer select codes,
// sequencer state encoding and the default empty/limit addresses.
package stack_port_pkg;

    localparam logic [15:0] STACK_BASE  = 16'hFFFF;
    localparam logic [15:0] STACK_LIMIT = 16'hF000;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Shared with the external stack pointer register
    localparam logic [1:0] SP_SEL_LOAD = 2'b00;
    localparam logic [1:0] SP_SEL_INC  = 2'b01;
    localparam logic [1:0] SP_SEL_DEC  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_WR = 3'd1,
        ST_POP_INC = 3'd2,
        ST_POP_RD  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/stack_port_if.sv
// Command handshake from the control unit plus the single-word memory bus.
// master = control unit / memory side, slave = stack_port.
interface stack_port_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

endinterface

// File: rtl/stack_port.sv
// Push/pop sequencer for the empty-descending CPU stack: turns LOAD/PUSH/POP
// commands into one memory transaction each and steers the external SP register.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | ready for a command; LOAD updates SP in the accept cycle
//   PUSH_WR  | write at SP, decrement SP on the ack cycle
//   POP_INC  | single-cycle SP increment ahead of the read
//   POP_RD   | read at the incremented SP, capture data on ack
//   DONE     | one-cycle completion pulse
module stack_port
    import stack_port_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    stack_port_if.slave        bus,
    output logic               done_o,
    output logic [15:0]        rdata_o,
    output logic               err_ovf_o,
    output logic               err_unf_o,
    input  logic               err_clr_i,
    input  logic [15:0]        sp_in_i,
    output logic [1:0]         sp_sel_o,
    output logic               sp_en_o,
    output logic [15:0]        sp_din_o
);

    state_e      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic        accept;
    logic        push_ovf;
    logic        pop_unf;

    assign accept   = bus.cmd_valid && (state_q == ST_IDLE);
    assign push_ovf = accept && (bus.cmd_op == OP_PUSH) && (sp_in_i < STACK_LIMIT);
    assign pop_unf  = accept && (bus.cmd_op == OP_POP) && (sp_in_i == STACK_BASE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= 16'h0000;
            rdata_q <= 16'h0000;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rdata_d = rdata_q;

        // A fresh error outranks a simultaneous clear
        ovf_d = push_ovf ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
        unf_d = pop_unf  ? 1'b1 : (err_clr_i ? 1'b0 : unf_q);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d = bus.cmd_data;
                    case (bus.cmd_op)
                        OP_PUSH: state_d = push_ovf ? ST_DONE : ST_PUSH_WR;
                        OP_POP:  state_d = pop_unf  ? ST_DONE : ST_POP_INC;
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_PUSH_WR: begin
                if (bus.mem_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_POP_INC: begin
                state_d = ST_POP_RD;
            end
            ST_POP_RD: begin
                if (bus.mem_ack) begin
                    rdata_d = bus.mem_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 16'h0000;
        sp_en_o       = 1'b0;
        sp_sel_o      = SP_SEL_LOAD;
        sp_din_o      = 16'h0000;
        done_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && (bus.cmd_op == OP_LOAD)) begin
                    sp_en_o  = 1'b1;
                    sp_sel_o = SP_SEL_LOAD;
                    sp_din_o = bus.cmd_data;
                end
            end
            ST_PUSH_WR: begin
                // SP only moves at the ack edge, so the address holds for the whole request
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = sp_in_i;
                bus.mem_wdata = data_q;
                if (bus.mem_ack) begin
                    sp_en_o  = 1'b1;
                    sp_sel_o = SP_SEL_DEC;
                end
            end
            ST_POP_INC: begin
                sp_en_o  = 1'b1;
                sp_sel_o = SP_SEL_INC;
            end
            ST_POP_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = sp_in_i;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                done_o = 1'b0;
            end
        endcase
    end

    assign rdata_o   = rdata_q;
    assign err_ovf_o = ovf_q;
    assign err_unf_o = unf_q;

endmodule

// File: tb/tb_stack_port.sv
// Scoreboard bench for stack_port with a behavioural SP register and memory.
module tb_stack_port;
    import stack_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    stack_port_if bus();

    logic        done;
    logic [15:0] rdata;
    logic        err_ovf, err_unf;
    logic        err_clr = 1'b0;
    logic [15:0] sp_q;
    logic [1:0]  sp_sel;
    logic        sp_en;
    logic [15:0] sp_din;

    stack_port dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .done_o    (done),
        .rdata_o   (rdata),
        .err_ovf_o (err_ovf),
        .err_unf_o (err_unf),
        .err_clr_i (err_clr),
        .sp_in_i   (sp_q),
        .sp_sel_o  (sp_sel),
        .sp_en_o   (sp_en),
        .sp_din_o  (sp_din)
    );

    // External stack pointer register
    always @(posedge clk or posedge rst) begin
        if (rst) sp_q <= 16'hFFFF;
        else if (sp_en) begin
            case (sp_sel)
                SP_SEL_LOAD: sp_q <= sp_din;
                SP_SEL_INC:  sp_q <= sp_q + 16'd1;
                SP_SEL_DEC:  sp_q <= sp_q - 16'd1;
                default:     sp_q <= sp_q;
            endcase
        end
    end

    // Memory with programmable ack wait
    logic [15:0] mem_arr [0:65535];
    logic [15:0] shadow  [0:65535];
    int          ack_wait = 0;
    int          wcnt;
    logic        stray_ack = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign bus.mem_ack   = (bus.mem_req && (wcnt == ack_wait)) || stray_ack;
    assign bus.mem_rdata = mem_arr[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ack && bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
    typedef struct { int cyc; logic [15:0] rdata; logic ovf; logic unf; logic [15:0] sp; } done_exp_t;
    mem_exp_t  exp_mem[$];
    done_exp_t exp_done[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference state
    logic [15:0] m_sp = 16'hFFFF;
    logic [15:0] m_rdata = 16'h0000;
    logic        m_ovf = 1'b0, m_unf = 1'b0;
    logic        busy = 1'b0;

    // Monitor
    logic        p_req, p_ack, p_we;
    logic [15:0] p_addr, p_wdata;
    always @(negedge clk) begin
        if (rst) begin
            p_req <= 1'b0;
            p_ack <= 1'b0;
        end else begin
            mem_exp_t  me;
            done_exp_t de;
            check("cmd_ready", 32'(bus.cmd_ready), 32'(!busy));
            if (p_req && !p_ack) begin
                check("req_hold",   32'(bus.mem_req),   32'd1);
                check("we_hold",    32'(bus.mem_we),    32'(p_we));
                check("addr_hold",  32'(bus.mem_addr),  32'(p_addr));
                check("wdata_hold", 32'(bus.mem_wdata), 32'(p_wdata));
            end
            if (p_req && p_ack) check("req_drop", 32'(bus.mem_req), 32'd0);
            if (bus.mem_req && exp_mem.size() == 0) check("unexpected_req", 32'd1, 32'd0);
            if (bus.mem_req && bus.mem_ack && exp_mem.size() != 0) begin
                me = exp_mem.pop_front();
                check("mem_we",   32'(bus.mem_we),   32'(me.we));
                check("mem_addr", 32'(bus.mem_addr), 32'(me.addr));
                if (me.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(me.wdata));
            end
            if (done) begin
                if (exp_done.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    de = exp_done.pop_front();
                    check("done_latency", 32'(cyc), 32'(de.cyc));
                    check("rdata",   32'(rdata),   32'(de.rdata));
                    check("err_ovf", 32'(err_ovf), 32'(de.ovf));
                    check("err_unf", 32'(err_unf), 32'(de.unf));
                    check("sp",      32'(sp_q),    32'(de.sp));
                end
            end
            p_req   <= bus.mem_req;
            p_ack   <= bus.mem_ack;
            p_we    <= bus.mem_we;
            p_addr  <= bus.mem_addr;
            p_wdata <= bus.mem_wdata;
        end
    end

    // Drive one command at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [1:0] op, input logic [15:0] d, input int wt,
                         input bit hold, input bit clr);
        done_exp_t de;
        mem_exp_t  me;
        int n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.cmd_ready), 32'd1);
        ack_wait      = wt;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        err_clr       = clr;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        de.cyc = cyc + 1;
        case (op)
            OP_LOAD: m_sp = d;
            OP_PUSH: begin
                if (m_sp < STACK_LIMIT) m_ovf = 1'b1;
                else begin
                    me = '{1'b1, m_sp, d};
                    exp_mem.push_back(me);
                    shadow[m_sp] = d;
                    m_sp = m_sp - 16'd1;
                    de.cyc = cyc + 2 + wt;
                end
            end
            OP_POP: begin
                if (m_sp == STACK_BASE) m_unf = 1'b1;
                else begin
                    m_sp = m_sp + 16'd1;
                    me = '{1'b0, m_sp, 16'h0000};
                    exp_mem.push_back(me);
                    m_rdata = shadow[m_sp];
                    de.cyc = cyc + 3 + wt;
                end
            end
            default: ;
        endcase
        de.rdata = m_rdata;
        de.ovf   = m_ovf;
        de.unf   = m_unf;
        de.sp    = m_sp;
        exp_done.push_back(de);
        @(posedge clk);
        #1;
        busy = 1'b1;
        if (!hold) bus.cmd_valid = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input bit hold);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        if (hold) bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] d, input int wt);
        issue(op, d, wt, 1'b0, 1'b0);
        wait_done(1'b0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check("clr_ovf", 32'(err_ovf), 32'd0);
        check("clr_unf", 32'(err_unf), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_ready",   32'(bus.cmd_ready), 32'd1);
        check("rst_done",    32'(done),          32'd0);
        check("rst_req",     32'(bus.mem_req),   32'd0);
        check("rst_we",      32'(bus.mem_we),    32'd0);
        check("rst_addr",    32'(bus.mem_addr),  32'd0);
        check("rst_wdata",   32'(bus.mem_wdata), 32'd0);
        check("rst_sp_en",   32'(sp_en),         32'd0);
        check("rst_sp_sel",  32'(sp_sel),        32'd0);
        check("rst_sp_din",  32'(sp_din),        32'd0);
        check("rst_rdata",   32'(rdata),         32'd0);
        check("rst_ovf",     32'(err_ovf),       32'd0);
        check("rst_unf",     32'(err_unf),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Underflow straight out of reset; a simultaneous clear loses to the error
        cmd(OP_POP, 16'h0000, 0);
        clear_errors();
        issue(OP_POP, 16'h0000, 0, 1'b0, 1'b1);
        wait_done(1'b0);
        clear_errors();

        cmd(OP_PUSH, 16'h1234, 2);
        cmd(OP_POP,  16'h0000, 1);
        cmd(OP_PUSH, 16'hAAAA, 0);
        cmd(OP_PUSH, 16'hBBBB, 1);
        cmd(OP_POP,  16'h0000, 0);
        cmd(OP_POP,  16'h0000, 3);

        // Limit boundary
        cmd(OP_LOAD, 16'hF000, 0);
        cmd(OP_PUSH, 16'h4321, 1);
        cmd(OP_PUSH, 16'h9999, 0);
        clear_errors();

        // Held cmd_valid, stray ack, reserved op
        cmd(OP_LOAD, 16'hFFFF, 0);
        issue(OP_PUSH, 16'h0101, 1, 1'b1, 1'b0);
        wait_done(1'b1);
        repeat (2) @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_sp",    32'(sp_q),  32'(m_sp));
        check("stray_rdata", 32'(rdata), 32'(m_rdata));
        cmd(OP_RSVD, 16'h5A5A, 0);

        // Reset with a read outstanding
        cmd(OP_PUSH, 16'h5555, 0);
        issue(OP_POP, 16'h0000, 40, 1'b0, 1'b0);
        @(negedge clk);
        check("rd_pending", 32'(bus.mem_req), 32'd1);
        check("rd_addr",    32'(bus.mem_addr), 32'(m_sp));
        #2 rst = 1'b1;
        #1;
        check("abort_req",   32'(bus.mem_req),   32'd0);
        check("abort_ready", 32'(bus.cmd_ready), 32'd1);
        check("abort_rdata", 32'(rdata),         32'd0);
        exp_mem.delete();
        exp_done.delete();
        busy    = 1'b0;
        m_sp    = 16'hFFFF;
        m_rdata = 16'h0000;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmd(OP_PUSH, 16'h7777, 1);

        // Random mix around the base
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)      cmd(OP_PUSH, 16'($urandom), $urandom_range(0, 3));
            else if (r < 9) cmd(OP_POP,  16'h0000,      $urandom_range(0, 3));
            else            cmd(OP_RSVD, 16'h0000,      0);
        end
        clear_errors();
        repeat (3) @(negedge clk);
        check("queues_empty", 32'(exp_mem.size() + exp_done.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stack_port.md
# stack_port

Push/pop sequencer for the CPU stack. Accepts push, pop and load commands from the control unit over a valid/ready handshake and turns each into a single-word memory transaction (req/ack). It also drives the select/enable/load controls of the existing stack pointer register. The stack is empty-descending: SP resets to 0xFFFF, a push writes at SP then decrements, a pop increments then reads at SP.

## Interface
- STACK_BASE, 16'hFFFF, SP value meaning empty; a pop here underflows.
- STACK_LIMIT, 16'hF000, lowest writable address; a push with SP below it overflows.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 = LOAD, 01 = PUSH, 10 = POP, 11 = reserved (treated as NOP, done pulse, no error).
- cmd_data  in  16  push data or LOAD value.
- done  out  1  one-cycle pulse when a command completes.
- rdata  out  16  pop result, valid with done for POP, held until next pop.
- err_ovf  out  1  sticky push overflow flag.
- err_unf  out  1  sticky pop underflow flag.
- err_clr  in  1  synchronous clear of both sticky flags.
- sp_in  in  16  current stack pointer value.
- sp_sel  out  2  00 = load sp_din, 01 = increment, 10 = decrement.
- sp_en  out  1  stack pointer write enable.
- sp_din  out  16  load value for the stack pointer.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  word address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  16  read data.

## Operation
- States:
  - IDLE, PUSH_WR, POP_INC, POP_RD, DONE.
  - A command is accepted on cmd_valid & cmd_ready; cmd_op and cmd_data are latched at acceptance.
- LOAD:
  - Acceptance cycle: sp_en=1, sp_sel=00, sp_din=cmd_data (combinational).
  - Next state DONE. No memory access.
- PUSH:
  - If sp_in < STACK_LIMIT at acceptance: set err_ovf, next state DONE, no memory access, SP unchanged.
  - Otherwise PUSH_WR: mem_req=1, mem_we=1, mem_addr=sp_in, mem_wdata=latched data.
  - On mem_ack: sp_en=1, sp_sel=10 in that same cycle, next state DONE.
- POP:
  - If sp_in == STACK_BASE at acceptance: set err_unf, next state DONE, rdata unchanged.
  - Otherwise POP_INC: sp_en=1, sp_sel=01 for exactly one cycle.
  - Then POP_RD: mem_req=1, mem_we=0, mem_addr=sp_in (already incremented).
  - On mem_ack: capture mem_rdata into rdata, next state DONE.
- DONE: done=1 for one cycle, then IDLE.
- sp_en is 0 in every cycle not listed above. sp_sel defaults to 00.
- err_clr and a new error in the same cycle: the error wins.
- SP arithmetic is 16-bit modulo; the base and limit checks prevent wrap during normal use.

## Timing
- Reset values:
  - State IDLE; cmd_ready=1.
  - done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - sp_en=0, sp_sel=00, sp_din=0.
  - rdata=0, err_ovf=0, err_unf=0.
- Latency, with ack arriving N cycles after req (N≥0 wait cycles):
  - LOAD: done 1 cycle after acceptance.
  - PUSH: done N+2 cycles after acceptance.
  - POP: done N+3 cycles after acceptance.
  - Error case: done 1 cycle after acceptance.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from req assertion until the ack cycle inclusive. req drops the cycle after ack.
- cmd_valid while busy is ignored (not queued). A back-to-back command can be accepted in the cycle after done.
- Reset mid-transaction: immediate (asynchronous) return to IDLE with mem_req=0. The memory side must tolerate an abandoned request.
- mem_ack outside PUSH_WR/POP_RD is ignored.

## Structure
- A shared CPU package holds:
  - op encodings (OP_LOAD, OP_PUSH, OP_POP);
  - SP select encodings (SP_SEL_LOAD/INC/DEC), shared with the stack pointer register;
  - the state enum;
  - default base/limit constants.
- Single module, no sub-modules. The stack pointer register stays external and is instantiated alongside in the CPU top.

## Test plan
- Reset, then PUSH 0x1234 with ack after 2 wait cycles:
  - write at 0xFFFF with data 0x1234, SP becomes 0xFFFE.
  - done 4 cycles after acceptance.
- PUSH 0xAAAA, PUSH 0xBBBB, POP, POP:
  - pops return 0xBBBB then 0xAAAA.
  - read addresses 0xFFFE then 0xFFFF; SP ends at 0xFFFF.
- POP right after reset: err_unf=1, no mem_req, done after 1 cycle. A following err_clr clears the flag.
- LOAD 0xF000, PUSH (writes 0xF000, SP 0xEFFF), PUSH: err_ovf=1, no write, SP stays 0xEFFF.
- Assert rst while in POP_RD with req pending: mem_req=0 at once, state IDLE, cmd_ready=1. Next PUSH behaves normally.
- Hold cmd_valid high during a PUSH:
  - only one command is accepted per transaction.
  - mem_ack pulsed while IDLE has no effect.
  - reserved op 11 gives a done pulse with no state change.
